// File: rtl/cdb_pkg.sv
// rtl/cdb_pkg.sv - shared widths and source encodings for the common data bus arbiter
package cdb_pkg;

    localparam int DATA_W = 32;
    localparam int TAG_W  = 8;

    localparam logic SRC_ALU = 1'b0;
    localparam logic SRC_MEM = 1'b1;

endpackage

// File: rtl/cdb_src_fifo.sv
// rtl/cdb_src_fifo.sv - per-source writeback FIFO feeding the common data bus
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   push, push_entry  enqueue request; accepted only while ready
//   pop               dequeue the head; ignored when empty
//   head              current head entry
//   count             number of stored entries (0..DEPTH)
//   ready             count < DEPTH, from the registered count only
//   almost_full       count >= DEPTH-1
module cdb_src_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 40,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  push_entry,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count,
    output logic          ready,
    output logic          almost_full
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // A full FIFO refuses a push even when its head leaves on the same edge.
    assign ready       = (count < CW'(DEPTH));
    assign almost_full = (count >= CW'(DEPTH - 1));
    assign do_push     = push && ready;
    assign do_pop      = pop && (count != '0);
    assign head        = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // Pointers are AW bits wide, so they wrap modulo DEPTH for free.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - ALU/MEM writeback arbiter driving the registered common data bus
// Optional feature macro: CDB_STARVE_GUARD_EN (ALU starvation guard).
// Ports:
//   clk, rst                                   clock, asynchronous active-low reset
//   alu_wb_valid/tag/data, alu_wb_ready        ALU writeback request into the ALU FIFO
//   mem_wb_valid/tag/data, mem_wb_ready        MEM writeback request into the MEM FIFO
//   alu_almost_full, mem_almost_full           scheduler throttle hints
//   cdb_valid, cdb_tag, cdb_data, cdb_src      registered bus; payload holds when not valid
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_wb_valid,
    input  logic [TAG_W-1:0]  alu_wb_tag,
    input  logic [DATA_W-1:0] alu_wb_data,
    output logic              alu_wb_ready,
    input  logic              mem_wb_valid,
    input  logic [TAG_W-1:0]  mem_wb_tag,
    input  logic [DATA_W-1:0] mem_wb_data,
    output logic              mem_wb_ready,
    output logic              alu_almost_full,
    output logic              mem_almost_full,
    output logic              cdb_valid,
    output logic [TAG_W-1:0]  cdb_tag,
    output logic [DATA_W-1:0] cdb_data,
    output logic              cdb_src
);

    localparam int W  = TAG_W + DATA_W;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [W-1:0]  alu_head;
    logic [W-1:0]  mem_head;
    logic [CW-1:0] alu_count;
    logic [CW-1:0] mem_count;
    logic          alu_ne;
    logic          mem_ne;
    logic          alu_grant;
    logic          mem_grant;
    logic          starve_fire;

    cdb_src_fifo #(.DEPTH(DEPTH), .W(W)) u_alu_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (alu_wb_valid),
        .push_entry  ({alu_wb_tag, alu_wb_data}),
        .pop         (alu_grant),
        .head        (alu_head),
        .count       (alu_count),
        .ready       (alu_wb_ready),
        .almost_full (alu_almost_full)
    );

    cdb_src_fifo #(.DEPTH(DEPTH), .W(W)) u_mem_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (mem_wb_valid),
        .push_entry  ({mem_wb_tag, mem_wb_data}),
        .pop         (mem_grant),
        .head        (mem_head),
        .count       (mem_count),
        .ready       (mem_wb_ready),
        .almost_full (mem_almost_full)
    );

    assign alu_ne = (alu_count != '0);
    assign mem_ne = (mem_count != '0);

    // MEM has priority; ALU gets the bus when MEM is empty or has starved it too long.
    assign alu_grant = alu_ne && (!mem_ne || starve_fire);
    assign mem_grant = mem_ne && !alu_grant;

`ifdef CDB_STARVE_GUARD_EN
    localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    logic [SW-1:0] starve_cnt;

    // The counter saturates naturally: reaching LIMIT forces an ALU win, which clears it.
    assign starve_fire = (starve_cnt == LIMIT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (alu_ne && mem_grant) begin
            starve_cnt <= starve_cnt + 1'b1;
        end else begin
            starve_cnt <= '0;
        end
    end
`else
    assign starve_fire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cdb_valid <= 1'b0;
            cdb_src   <= 1'b0;
            cdb_tag   <= '0;
            cdb_data  <= '0;
        end else begin
            cdb_valid <= alu_grant || mem_grant;
            if (alu_grant) begin
                {cdb_tag, cdb_data} <= alu_head;
                cdb_src             <= SRC_ALU;
            end else if (mem_grant) begin
                {cdb_tag, cdb_data} <= mem_head;
                cdb_src             <= SRC_MEM;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - self-checking bench for cdb_arbiter against a queue-based model
module tb_cdb_arbiter;

    localparam int DEPTH        = 4;
    localparam int STARVE_LIMIT = 3;
`ifdef CDB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        alu_wb_valid = 1'b0;
    logic [7:0]  alu_wb_tag = '0;
    logic [31:0] alu_wb_data = '0;
    logic        alu_wb_ready;
    logic        mem_wb_valid = 1'b0;
    logic [7:0]  mem_wb_tag = '0;
    logic [31:0] mem_wb_data = '0;
    logic        mem_wb_ready;
    logic        alu_almost_full;
    logic        mem_almost_full;
    logic        cdb_valid;
    logic [7:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        cdb_src;

    cdb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk             (clk),
        .rst             (rst),
        .alu_wb_valid    (alu_wb_valid),
        .alu_wb_tag      (alu_wb_tag),
        .alu_wb_data     (alu_wb_data),
        .alu_wb_ready    (alu_wb_ready),
        .mem_wb_valid    (mem_wb_valid),
        .mem_wb_tag      (mem_wb_tag),
        .mem_wb_data     (mem_wb_data),
        .mem_wb_ready    (mem_wb_ready),
        .alu_almost_full (alu_almost_full),
        .mem_almost_full (mem_almost_full),
        .cdb_valid       (cdb_valid),
        .cdb_tag         (cdb_tag),
        .cdb_data        (cdb_data),
        .cdb_src         (cdb_src)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    logic [39:0] alu_q[$];
    logic [39:0] mem_q[$];
    int          starve = 0;
    logic        exp_valid = 1'b0;
    logic [7:0]  exp_tag = '0;
    logic [31:0] exp_data = '0;
    logic        exp_src = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        check("cdb_valid", 64'(cdb_valid), 64'(exp_valid));
        check("cdb_tag", 64'(cdb_tag), 64'(exp_tag));
        check("cdb_data", 64'(cdb_data), 64'(exp_data));
        check("cdb_src", 64'(cdb_src), 64'(exp_src));
        check("alu_ready", 64'(alu_wb_ready), 64'(alu_q.size() < DEPTH));
        check("mem_ready", 64'(mem_wb_ready), 64'(mem_q.size() < DEPTH));
        check("alu_af", 64'(alu_almost_full), 64'(alu_q.size() >= DEPTH - 1));
        check("mem_af", 64'(mem_almost_full), 64'(mem_q.size() >= DEPTH - 1));
    endtask

    task automatic step(input logic av, input logic [7:0] at, input logic [31:0] ad,
                        input logic mv, input logic [7:0] mt, input logic [31:0] md);
        bit a_ne, m_ne, acc_a, acc_m, alu_win;
        logic [39:0] e;
        alu_wb_valid = av; alu_wb_tag = at; alu_wb_data = ad;
        mem_wb_valid = mv; mem_wb_tag = mt; mem_wb_data = md;
        @(posedge clk);
        a_ne  = alu_q.size() != 0;
        m_ne  = mem_q.size() != 0;
        acc_a = av && (alu_q.size() < DEPTH);
        acc_m = mv && (mem_q.size() < DEPTH);
        alu_win = a_ne && (!m_ne || (GUARD && starve == STARVE_LIMIT));
        if (alu_win) begin
            e = alu_q.pop_front();
            exp_valid = 1'b1; exp_tag = e[39:32]; exp_data = e[31:0]; exp_src = 1'b0;
        end else if (m_ne) begin
            e = mem_q.pop_front();
            exp_valid = 1'b1; exp_tag = e[39:32]; exp_data = e[31:0]; exp_src = 1'b1;
        end else begin
            exp_valid = 1'b0;
        end
        if (GUARD) starve = (a_ne && !alu_win) ? starve + 1 : 0;
        if (acc_a) alu_q.push_back({at, ad});
        if (acc_m) mem_q.push_back({mt, md});
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h0, 32'h0, 1'b0, 8'h0, 32'h0);
    endtask

    task automatic do_reset();
        alu_wb_valid = 1'b0;
        mem_wb_valid = 1'b0;
        rst = 1'b0;
        #2;
        alu_q.delete(); mem_q.delete(); starve = 0;
        exp_valid = 1'b0; exp_tag = '0; exp_data = '0; exp_src = 1'b0;
        check_outputs();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int idx, nval, nalu, expn;
        do_reset();

        // single ALU writeback, one cycle of latency
        step(1'b1, 8'h12, 32'hDEADBEEF, 1'b0, 8'h0, 32'h0);
        check("single_nolat", 64'(cdb_valid), 64'd0);
        step(1'b0, 8'h0, 32'h0, 1'b0, 8'h0, 32'h0);
        check("single_valid", 64'(cdb_valid), 64'd1);
        check("single_tag", 64'(cdb_tag), 64'h12);
        check("single_data", 64'(cdb_data), 64'hDEADBEEF);
        check("single_src", 64'(cdb_src), 64'd0);
        idle(2);
        check("hold_tag", 64'(cdb_tag), 64'h12);

        // simultaneous ALU/MEM: MEM first
        step(1'b1, 8'h01, 32'h1111, 1'b1, 8'h02, 32'h2222);
        step(1'b0, 8'h0, 32'h0, 1'b0, 8'h0, 32'h0);
        check("both_first_tag", 64'(cdb_tag), 64'h02);
        check("both_first_src", 64'(cdb_src), 64'd1);
        step(1'b0, 8'h0, 32'h0, 1'b0, 8'h0, 32'h0);
        check("both_second_tag", 64'(cdb_tag), 64'h01);
        check("both_second_src", 64'(cdb_src), 64'd0);
        idle(2);

        // starvation: MEM valid 10 cycles, ALU holds one entry
        do_reset();
        idx = 0; nval = 0;
        for (int i = 0; i < 14; i++) begin
            step(i == 0, 8'hA0, 32'hA0A0, i < 10, 8'(8'h40 + i), 32'(i));
            if (cdb_valid) begin
                nval++;
                if (cdb_src == 1'b0 && idx == 0) idx = nval;
            end
        end
        check("starve_grant_idx", 64'(idx), GUARD ? 64'd4 : 64'd11);
        idle(4);

        // ALU fill against a saturating MEM stream
        do_reset();
        nalu = 0;
        for (int k = 1; k <= 5; k++) begin
            step(1'b1, 8'(8'h80 + k), 32'(k), 1'b1, 8'(8'hC0 + k), 32'(k));
            if (k <= 4) begin
                check("fill_af", 64'(alu_almost_full), 64'(k >= 3));
                check("fill_ready", 64'(alu_wb_ready), 64'(k < 4));
            end
            if (cdb_valid && cdb_src == 1'b0) nalu++;
        end
        for (int i = 0; i < 14; i++) begin
            step(1'b0, 8'h0, 32'h0, 1'b0, 8'h0, 32'h0);
            if (cdb_valid && cdb_src == 1'b0) nalu++;
        end
        check("fill_alu_count", 64'(nalu), 64'd4);

        // reset mid-stream with entries queued
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h50 + i), 32'(i), 1'b1, 8'(8'h60 + i), 32'(i));
        check("pre_reset_queued", 64'(alu_q.size() + mem_q.size() >= 3), 64'd1);
        do_reset();
        check("rst_valid", 64'(cdb_valid), 64'd0);
        check("rst_ready", 64'(alu_wb_ready & mem_wb_ready), 64'd1);
        nval = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 8'h0, 32'h0, 1'b0, 8'h0, 32'h0);
            if (cdb_valid) nval++;
        end
        check("rst_no_stale", 64'(nval), 64'd0);

        // 3*DEPTH sequential pushes on ALU across pointer wrap
        do_reset();
        expn = 0;
        for (int i = 0; i < 3 * DEPTH; i++) begin
            step(1'b1, 8'(i), $urandom, 1'b0, 8'h0, 32'h0);
            if (cdb_valid) begin
                check("wrap_order", 64'(cdb_tag), 64'(expn));
                expn++;
            end
            if ($urandom_range(0, 1) == 1) begin
                step(1'b0, 8'h0, 32'h0, 1'b0, 8'h0, 32'h0);
                if (cdb_valid) begin
                    check("wrap_order", 64'(cdb_tag), 64'(expn));
                    expn++;
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 8'h0, 32'h0, 1'b0, 8'h0, 32'h0);
            if (cdb_valid) begin
                check("wrap_order", 64'(cdb_tag), 64'(expn));
                expn++;
            end
        end
        check("wrap_count", 64'(expn), 64'(3 * DEPTH));

        // randomized traffic with one reset in the middle
        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset();
            step($urandom_range(0, 2) != 0, 8'($urandom), $urandom,
                 $urandom_range(0, 2) != 0, 8'($urandom), $urandom);
        end
        idle(2 * DEPTH + 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 4, entries per source FIFO (power of two, >=2).
REQ-002 SHALL have parameter STARVE_LIMIT, default 3, max consecutive lost arbitrations of a non-empty ALU FIFO.
REQ-003 SHALL have port clk input 1, clock, and rst input 1, reset; reset rst, asynchronous, active-low; clock clk.
REQ-004 SHALL have ports alu_wb_valid input 1, alu_wb_tag input TAG_W, alu_wb_data input DATA_W: ALU writeback request, tag = {warp, dest reg}.
REQ-005 SHALL have port alu_wb_ready output 1: ALU FIFO accepts this cycle.
REQ-006 SHALL have ports mem_wb_valid input 1, mem_wb_tag input TAG_W, mem_wb_data input DATA_W, mem_wb_ready output 1: MEM writeback, same semantics.
REQ-007 SHALL have ports alu_almost_full output 1 and mem_almost_full output 1: scheduler throttle hints.
REQ-008 SHALL have ports cdb_valid output 1, cdb_tag output TAG_W, cdb_data output DATA_W, cdb_src output 1 (0=ALU, 1=MEM): registered common data bus.

Function
REQ-009 SHALL enqueue into a source FIFO when valid && ready at a clk rising edge.
REQ-010 SHALL drive ready = (count < DEPTH), a function of the registered count only; a full FIFO refuses enqueue even if popped the same cycle.
REQ-011 SHALL drive almost_full = (count >= DEPTH-1).
REQ-012 SHALL arbitrate each cycle among non-empty FIFO heads: MEM wins by default; ALU wins when MEM is empty or the starvation guard fires.
REQ-013 SHALL pop exactly one head per cycle at most and register it onto cdb_* at the same edge; cdb_valid = 0 when both FIFOs are empty.
REQ-014 SHALL have minimum latency 1 cycle: an entry enqueued at edge N appears on cdb_* after edge N+1.
REQ-015 SHALL hold cdb_tag/cdb_data/cdb_src at their previous values when cdb_valid = 0.
REQ-016 SHALL preserve per-source FIFO order; cross-source order is arbitration order.
REQ-017 SHALL keep pointers of width log2(DEPTH) that wrap modulo DEPTH, and counts of width log2(DEPTH)+1.
REQ-018 SHALL, on a simultaneous enqueue and pop of the same FIFO, leave count unchanged and update both pointers.
REQ-019 SHALL never drop or duplicate an accepted entry.

Reset
REQ-020 SHALL, on rst low, asynchronously clear FIFO pointers, counts, starvation counter, cdb_valid, cdb_src, cdb_tag, and cdb_data to 0.
REQ-021 SHALL drive alu_wb_ready = mem_wb_ready = 1 and almost_full = 0 while and after reset, for DEPTH >= 2.
REQ-022 SHALL discard in-flight FIFO contents on reset mid-operation; no cdb_valid for them after release.

Configuration
REQ-023 SHALL, with CDB_STARVE_GUARD_EN defined, keep a starvation counter that increments each cycle the ALU FIFO is non-empty and MEM wins, clears when ALU wins or the ALU FIFO is empty, and forces an ALU win when the counter equals STARVE_LIMIT.
REQ-024 SHALL, without CDB_STARVE_GUARD_EN, use strict MEM priority, omit the counter, and leave STARVE_LIMIT unused.

Structure
REQ-025 SHALL take DATA_W (32), TAG_W (8), and the source encoding constants SRC_ALU/SRC_MEM from shared package cdb_pkg.
REQ-026 SHALL instantiate one sub-module cdb_src_fifo, parameterized by DEPTH, twice (ALU, MEM); it provides push, pop, head, count, ready, and almost_full.

Verification
REQ-027 SHALL cover single ALU write, tag 0x12, data 0xDEADBEEF, MEM idle -> cdb_valid one cycle later with tag 0x12, data 0xDEADBEEF, src 0.
REQ-028 SHALL cover ALU and MEM valid in the same cycle, tags 0x01 and 0x02 -> cdb shows 0x02 (src 1), then 0x01 (src 0) on consecutive cycles.
REQ-029 SHALL cover MEM valid every cycle for 10 cycles with ALU holding 1 entry, guard enabled -> ALU granted on the 4th arbitration; guard disabled -> ALU granted only after MEM drains.
REQ-030 SHALL cover 4 ALU pushes with MEM saturating -> alu_almost_full rises at count 3, alu_wb_ready = 0 at count 4, no 5th entry accepted.
REQ-031 SHALL cover asserting rst low mid-stream with 3 entries queued -> cdb_valid = 0, ready = 1, and no stale entries after release.
REQ-032 SHALL cover 3*DEPTH sequential pushes/pops on one source -> output order matches input order across pointer wrap-around.
